// File: rtl/mmu_tlb_pipe.sv
// Registered MIPS32 dual-page TLB: one instruction and one data translation per cycle,
// plus TLBP/TLBR/TLBWI/TLBWR execution and the Random register.
module mmu_tlb_pipe #(
   parameter int TLBNUM = 16,
   localparam int IW = $clog2(TLBNUM)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          kseg0_uncache,
   input  logic          inst_req,
   input  logic [31:0]   inst_vaddr,
   input  logic          data_req,
   input  logic [31:0]   data_vaddr,
   input  logic          data_wr,
   output logic          inst_rsp_valid,
   output logic [31:0]   inst_paddr,
   output logic          inst_uncache,
   output logic          inst_refill,
   output logic          inst_invalid,
   output logic          data_rsp_valid,
   output logic [31:0]   data_paddr,
   output logic          data_uncache,
   output logic          data_refill,
   output logic          data_invalid,
   output logic          data_modified,
   input  logic [31:0]   c0_entryhi,
   input  logic [31:0]   c0_entrylo0,
   input  logic [31:0]   c0_entrylo1,
   input  logic [31:0]   c0_index,
   input  logic [IW-1:0] c0_wired,
   input  logic          tlbp,
   input  logic          tlbr,
   input  logic          tlbwi,
   input  logic          tlbwr,
   output logic          tlb_op_done,
   output logic [31:0]   tlbp_index,
   output logic [31:0]   r_entryhi,
   output logic [31:0]   r_entrylo0,
   output logic [31:0]   r_entrylo1,
   output logic [IW-1:0] random
);

   typedef struct packed {
      logic [31:0] paddr;
      logic        unc;
      logic        refill;
      logic        invalid;
      logic        modified;
   } lk_t;

   logic [18:0] vpn2_q [TLBNUM];
   logic [18:0] vpn2_d [TLBNUM];
   logic [7:0]  asid_q [TLBNUM];
   logic [7:0]  asid_d [TLBNUM];
   logic        g_q    [TLBNUM];
   logic        g_d    [TLBNUM];
   logic [19:0] pfn_q  [TLBNUM][2];
   logic [19:0] pfn_d  [TLBNUM][2];
   logic [2:0]  c_q    [TLBNUM][2];
   logic [2:0]  c_d    [TLBNUM][2];
   logic        d_q    [TLBNUM][2];
   logic        d_d    [TLBNUM][2];
   logic        v_q    [TLBNUM][2];
   logic        v_d    [TLBNUM][2];

   logic          inst_rsp_valid_q, inst_rsp_valid_d;
   logic          data_rsp_valid_q, data_rsp_valid_d;
   lk_t           inst_res_q, inst_res_d;
   lk_t           data_res_q, data_res_d;
   logic          op_done_q, op_done_d;
   logic [31:0]   tlbp_index_q, tlbp_index_d;
   logic [31:0]   r_entryhi_q, r_entryhi_d;
   logic [31:0]   r_entrylo0_q, r_entrylo0_d;
   logic [31:0]   r_entrylo1_q, r_entrylo1_d;
   logic [IW-1:0] random_q, random_d;

   logic [IW-1:0] widx;
   logic [IW-1:0] ridx;
   logic [IW:0]   probe;
   logic [31:0]   lo_sel;

   // Lowest matching index wins: scan downward so the last hit recorded is the smallest.
   function automatic logic [IW:0] find(input logic [18:0] vpn, input logic [7:0] asid);
      logic [IW:0] r;
      r = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (vpn2_q[i] == vpn && (g_q[i] || asid_q[i] == asid)) r = {1'b1, IW'(i)};
      end
      return r;
   endfunction

   function automatic lk_t xlate(input logic [31:0] va, input logic wr);
      lk_t         r;
      logic [IW:0] f;
      logic [IW-1:0] ix;
      logic        pg;
      r  = '0;
      f  = find(va[31:13], c0_entryhi[7:0]);
      ix = f[IW-1:0];
      pg = va[12];
      if (!(va[31] == 1'b0 || va[31:30] == 2'b11)) begin
         r.paddr = {3'b000, va[28:0]};
         r.unc   = (va[31:29] == 3'b101) | ((va[31:29] == 3'b100) & kseg0_uncache);
      end else if (!f[IW]) begin
         r.refill = 1'b1;
         r.unc    = 1'b1;
      end else if (!v_q[ix][pg]) begin
         r.invalid = 1'b1;
         r.unc     = 1'b1;
      end else if (wr && !d_q[ix][pg]) begin
         r.modified = 1'b1;
         r.unc      = 1'b1;
      end else begin
         r.paddr = {pfn_q[ix][pg], va[11:0]};
         r.unc   = (c_q[ix][pg] != 3'b011);
      end
      return r;
   endfunction

   always_comb begin
      vpn2_d = vpn2_q;
      asid_d = asid_q;
      g_d    = g_q;
      pfn_d  = pfn_q;
      c_d    = c_q;
      d_d    = d_q;
      v_d    = v_q;
      tlbp_index_d = tlbp_index_q;
      r_entryhi_d  = r_entryhi_q;
      r_entrylo0_d = r_entrylo0_q;
      r_entrylo1_d = r_entrylo1_q;
      inst_res_d   = inst_res_q;
      data_res_d   = data_res_q;
      lo_sel       = '0;

      inst_rsp_valid_d = inst_req;
      data_rsp_valid_d = data_req;
      if (inst_req) inst_res_d = xlate(inst_vaddr, 1'b0);
      if (data_req) data_res_d = xlate(data_vaddr, data_wr);

      widx  = tlbwi ? c0_index[IW-1:0] : random_q;
      ridx  = c0_index[IW-1:0];
      probe = find(c0_entryhi[31:13], c0_entryhi[7:0]);
      op_done_d = tlbwi | tlbwr | tlbr | tlbp;

      if (tlbwi || tlbwr) begin
         vpn2_d[widx] = c0_entryhi[31:13];
         asid_d[widx] = c0_entryhi[7:0];
         g_d[widx]    = c0_entrylo0[0] & c0_entrylo1[0];
         for (int p = 0; p < 2; p++) begin
            lo_sel         = (p == 0) ? c0_entrylo0 : c0_entrylo1;
            pfn_d[widx][p] = lo_sel[25:6];
            c_d[widx][p]   = lo_sel[5:3];
            d_d[widx][p]   = lo_sel[2];
            v_d[widx][p]   = lo_sel[1];
         end
      end else if (tlbr) begin
         r_entryhi_d  = {vpn2_q[ridx], 5'b0, asid_q[ridx]};
         r_entrylo0_d = {6'b0, pfn_q[ridx][0], c_q[ridx][0], d_q[ridx][0], v_q[ridx][0], g_q[ridx]};
         r_entrylo1_d = {6'b0, pfn_q[ridx][1], c_q[ridx][1], d_q[ridx][1], v_q[ridx][1], g_q[ridx]};
      end else if (tlbp) begin
         tlbp_index_d = probe[IW] ? 32'(probe[IW-1:0]) : 32'h8000_0000;
      end

      // Wrap to the top on hitting Wired or zero; a Wired at or above the top pins Random there.
      if (c0_wired >= IW'(TLBNUM - 1) || random_q == c0_wired || random_q == '0)
         random_d = IW'(TLBNUM - 1);
      else
         random_d = random_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TLBNUM; i++) begin
            vpn2_q[i] <= '0;
            asid_q[i] <= '0;
            g_q[i]    <= 1'b0;
            for (int p = 0; p < 2; p++) begin
               pfn_q[i][p] <= '0;
               c_q[i][p]   <= '0;
               d_q[i][p]   <= 1'b0;
               v_q[i][p]   <= 1'b0;
            end
         end
         inst_rsp_valid_q <= 1'b0;
         data_rsp_valid_q <= 1'b0;
         inst_res_q       <= '0;
         data_res_q       <= '0;
         op_done_q        <= 1'b0;
         tlbp_index_q     <= '0;
         r_entryhi_q      <= '0;
         r_entrylo0_q     <= '0;
         r_entrylo1_q     <= '0;
         random_q         <= IW'(TLBNUM - 1);
      end else begin
         vpn2_q <= vpn2_d;
         asid_q <= asid_d;
         g_q    <= g_d;
         pfn_q  <= pfn_d;
         c_q    <= c_d;
         d_q    <= d_d;
         v_q    <= v_d;
         inst_rsp_valid_q <= inst_rsp_valid_d;
         data_rsp_valid_q <= data_rsp_valid_d;
         inst_res_q       <= inst_res_d;
         data_res_q       <= data_res_d;
         op_done_q        <= op_done_d;
         tlbp_index_q     <= tlbp_index_d;
         r_entryhi_q      <= r_entryhi_d;
         r_entrylo0_q     <= r_entrylo0_d;
         r_entrylo1_q     <= r_entrylo1_d;
         random_q         <= random_d;
      end
   end

   assign inst_rsp_valid = inst_rsp_valid_q;
   assign inst_paddr     = inst_res_q.paddr;
   assign inst_uncache   = inst_res_q.unc;
   assign inst_refill    = inst_res_q.refill;
   assign inst_invalid   = inst_res_q.invalid;
   assign data_rsp_valid = data_rsp_valid_q;
   assign data_paddr     = data_res_q.paddr;
   assign data_uncache   = data_res_q.unc;
   assign data_refill    = data_res_q.refill;
   assign data_invalid   = data_res_q.invalid;
   assign data_modified  = data_res_q.modified;
   assign tlb_op_done    = op_done_q;
   assign tlbp_index     = tlbp_index_q;
   assign r_entryhi      = r_entryhi_q;
   assign r_entrylo0     = r_entrylo0_q;
   assign r_entrylo1     = r_entrylo1_q;
   assign random         = random_q;

   logic unused_ok;
   assign unused_ok = ^{c0_index[31:IW], c0_entryhi[12:8], c0_entrylo0[31:26],
                        c0_entrylo1[31:26], inst_res_q.modified};

endmodule

// File: tb/tb_mmu_tlb_pipe.sv
// Bench for mmu_tlb_pipe: constant vectors for the documented scenarios plus
// randomized traffic checked every cycle against an abstract TLB model.
module tb_mmu_tlb_pipe;
   localparam int N = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, kseg0_uncache, inst_req, data_req, data_wr;
   logic [31:0] inst_vaddr, data_vaddr;
   logic inst_rsp_valid, inst_uncache, inst_refill, inst_invalid;
   logic data_rsp_valid, data_uncache, data_refill, data_invalid, data_modified;
   logic [31:0] inst_paddr, data_paddr;
   logic [31:0] c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index;
   logic [3:0]  c0_wired;
   logic tlbp, tlbr, tlbwi, tlbwr, tlb_op_done;
   logic [31:0] tlbp_index, r_entryhi, r_entrylo0, r_entrylo1;
   logic [3:0]  random;

   mmu_tlb_pipe #(.TLBNUM(N)) dut (
      .clk(clk), .rst_n(rst_n), .kseg0_uncache(kseg0_uncache),
      .inst_req(inst_req), .inst_vaddr(inst_vaddr),
      .data_req(data_req), .data_vaddr(data_vaddr), .data_wr(data_wr),
      .inst_rsp_valid(inst_rsp_valid), .inst_paddr(inst_paddr), .inst_uncache(inst_uncache),
      .inst_refill(inst_refill), .inst_invalid(inst_invalid),
      .data_rsp_valid(data_rsp_valid), .data_paddr(data_paddr), .data_uncache(data_uncache),
      .data_refill(data_refill), .data_invalid(data_invalid), .data_modified(data_modified),
      .c0_entryhi(c0_entryhi), .c0_entrylo0(c0_entrylo0), .c0_entrylo1(c0_entrylo1),
      .c0_index(c0_index), .c0_wired(c0_wired),
      .tlbp(tlbp), .tlbr(tlbr), .tlbwi(tlbwi), .tlbwr(tlbwr),
      .tlb_op_done(tlb_op_done), .tlbp_index(tlbp_index),
      .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
      .random(random)
   );

   typedef struct {
      logic [31:0] pa;
      logic        unc, rf, inv, md;
   } res_t;

   typedef struct {
      logic [31:0] va;
      logic [7:0]  asid;
      logic        wr, k0u;
      logic [31:0] pa;
      logic        unc, rf, inv, md;
   } vec_t;

   // Abstract TLB contents
   logic [18:0] m_vpn2 [N];
   logic [7:0]  m_asid [N];
   logic        m_g    [N];
   logic [19:0] m_pfn  [N][2];
   logic [2:0]  m_c    [N][2];
   logic        m_d    [N][2];
   logic        m_v    [N][2];
   int          m_rand;

   res_t        e_i, e_d;
   logic        e_irv, e_drv, e_done;
   logic [31:0] e_tp, e_rhi, e_rl0, e_rl1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic res_t zres();
      res_t r;
      r.pa = 32'h0; r.unc = 1'b0; r.rf = 1'b0; r.inv = 1'b0; r.md = 1'b0;
      return r;
   endfunction

   task automatic mreset();
      for (int i = 0; i < N; i++) begin
         m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            m_pfn[i][p] = '0; m_c[i][p] = '0; m_d[i][p] = 1'b0; m_v[i][p] = 1'b0;
         end
      end
      m_rand = N - 1;
      e_i = zres(); e_d = zres();
      e_irv = 1'b0; e_drv = 1'b0; e_done = 1'b0;
      e_tp = '0; e_rhi = '0; e_rl0 = '0; e_rl1 = '0;
   endtask

   function automatic int mfind(input logic [18:0] vpn, input logic [7:0] asid);
      for (int i = 0; i < N; i++)
         if (m_vpn2[i] == vpn && (m_g[i] || m_asid[i] == asid)) return i;
      return -1;
   endfunction

   function automatic res_t mxlate(input logic [31:0] va, input logic [7:0] asid,
                                   input logic wr, input logic k0u);
      res_t r;
      int   ix, pg;
      r = zres();
      if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
         r.pa  = va & 32'h1FFF_FFFF;
         r.unc = (va >= 32'hA000_0000) || k0u;
         return r;
      end
      ix = mfind(va[31:13], asid);
      pg = int'(va[12]);
      r.unc = 1'b1;
      if (ix < 0) r.rf = 1'b1;
      else if (!m_v[ix][pg]) r.inv = 1'b1;
      else if (wr && !m_d[ix][pg]) r.md = 1'b1;
      else begin
         r.unc = (m_c[ix][pg] != 3'd3);
         r.pa  = {m_pfn[ix][pg], va[11:0]};
      end
      return r;
   endfunction

   task automatic mwrite(input int idx);
      m_vpn2[idx] = c0_entryhi[31:13];
      m_asid[idx] = c0_entryhi[7:0];
      m_g[idx]    = c0_entrylo0[0] & c0_entrylo1[0];
      m_pfn[idx][0] = c0_entrylo0[25:6]; m_c[idx][0] = c0_entrylo0[5:3];
      m_d[idx][0]   = c0_entrylo0[2];    m_v[idx][0] = c0_entrylo0[1];
      m_pfn[idx][1] = c0_entrylo1[25:6]; m_c[idx][1] = c0_entrylo1[5:3];
      m_d[idx][1]   = c0_entrylo1[2];    m_v[idx][1] = c0_entrylo1[1];
   endtask

   task automatic cmp_all();
      chk("inst_rsp_valid", 32'(inst_rsp_valid), 32'(e_irv));
      chk("inst_paddr",     inst_paddr,          e_i.pa);
      chk("inst_uncache",   32'(inst_uncache),   32'(e_i.unc));
      chk("inst_refill",    32'(inst_refill),    32'(e_i.rf));
      chk("inst_invalid",   32'(inst_invalid),   32'(e_i.inv));
      chk("data_rsp_valid", 32'(data_rsp_valid), 32'(e_drv));
      chk("data_paddr",     data_paddr,          e_d.pa);
      chk("data_uncache",   32'(data_uncache),   32'(e_d.unc));
      chk("data_refill",    32'(data_refill),    32'(e_d.rf));
      chk("data_invalid",   32'(data_invalid),   32'(e_d.inv));
      chk("data_modified",  32'(data_modified),  32'(e_d.md));
      chk("tlb_op_done",    32'(tlb_op_done),    32'(e_done));
      chk("tlbp_index",     tlbp_index,          e_tp);
      chk("r_entryhi",      r_entryhi,           e_rhi);
      chk("r_entrylo0",     r_entrylo0,          e_rl0);
      chk("r_entrylo1",     r_entrylo1,          e_rl1);
      chk("random",         32'(random),         32'(m_rand));
   endtask

   // One clock: predict from the inputs now applied, then compare after the edge.
   task automatic tick();
      int ix, ri;
      e_irv = inst_req;
      e_drv = data_req;
      if (inst_req) e_i = mxlate(inst_vaddr, c0_entryhi[7:0], 1'b0, kseg0_uncache);
      if (data_req) e_d = mxlate(data_vaddr, c0_entryhi[7:0], data_wr, kseg0_uncache);
      e_done = tlbwi | tlbwr | tlbr | tlbp;
      ri = int'(c0_index[3:0]);
      if (tlbwi) mwrite(ri);
      else if (tlbwr) mwrite(m_rand);
      else if (tlbr) begin
         e_rhi = {m_vpn2[ri], 5'b0, m_asid[ri]};
         e_rl0 = {6'b0, m_pfn[ri][0], m_c[ri][0], m_d[ri][0], m_v[ri][0], m_g[ri]};
         e_rl1 = {6'b0, m_pfn[ri][1], m_c[ri][1], m_d[ri][1], m_v[ri][1], m_g[ri]};
      end else if (tlbp) begin
         ix = mfind(c0_entryhi[31:13], c0_entryhi[7:0]);
         e_tp = (ix < 0) ? 32'h8000_0000 : 32'(ix);
      end
      if (int'(c0_wired) >= N - 1 || m_rand == int'(c0_wired) || m_rand == 0) m_rand = N - 1;
      else m_rand = m_rand - 1;
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   task automatic idle();
      inst_req = 0; data_req = 0; data_wr = 0;
      tlbp = 0; tlbr = 0; tlbwi = 0; tlbwr = 0;
   endtask

   function automatic logic [31:0] pick_va();
      logic [18:0] vs [4];
      vs[0] = 19'h00201; vs[1] = 19'h00300; vs[2] = 19'h60000; vs[3] = 19'h00400;
      case ($urandom_range(0, 3))
         0: return {vs[$urandom_range(0, 3)], 13'($urandom)};
         1: return {3'b110, 29'($urandom)};
         2: return {3'b100, 29'($urandom)} | (($urandom_range(0, 1) == 1) ? 32'h2000_0000 : 32'h0);
         default: return $urandom;
      endcase
   endfunction

   vec_t tv [8];
   int   found;

   initial begin
      rst_n = 0; kseg0_uncache = 0; c0_wired = 4'd4;
      inst_vaddr = 0; data_vaddr = 0;
      c0_entryhi = 0; c0_entrylo0 = 0; c0_entrylo1 = 0; c0_index = 0;
      idle();
      mreset();
      #12;
      cmp_all();
      @(posedge clk); #1;
      rst_n = 1;

      // Random register from reset with Wired = 4
      chk("rand_seq0", 32'(random), 32'd15);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("rand_seq", 32'(random), (k <= 11) ? 32'(15 - k) : 32'd15);
      end

      // Unmapped segments
      inst_req = 1; inst_vaddr = 32'hBFC0_0000;
      tick();
      chk("kseg1_valid", 32'(inst_rsp_valid), 32'd1);
      chk("kseg1_paddr", inst_paddr, 32'h1FC0_0000);
      chk("kseg1_unc", 32'(inst_uncache), 32'd1);
      inst_vaddr = 32'h8000_1000;
      tick();
      chk("kseg0_paddr", inst_paddr, 32'h0000_1000);
      chk("kseg0_unc", 32'(inst_uncache), 32'd0);
      inst_req = 0;
      tick();
      chk("inst_valid_drop", 32'(inst_rsp_valid), 32'd0);
      chk("inst_paddr_hold", inst_paddr, 32'h0000_1000);

      // TLBWI entry 3: even page valid/dirty, odd page invalid
      c0_entryhi = 32'h0040_2005; c0_entrylo0 = 32'h0048_D15E; c0_entrylo1 = 32'h0;
      c0_index = 32'd3; tlbwi = 1;
      tick();
      chk("wi_done", 32'(tlb_op_done), 32'd1);
      tlbwi = 0;
      tick();
      chk("done_pulse", 32'(tlb_op_done), 32'd0);

      tv[0] = '{32'h0040_2ABC, 8'd5, 1'b0, 1'b0, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[1] = '{32'h0040_3000, 8'd5, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0};
      tv[2] = '{32'h0040_2ABC, 8'd6, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
      tv[3] = '{32'h0040_2004, 8'd5, 1'b1, 1'b0, 32'h1234_5004, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[4] = '{32'hA000_0010, 8'd5, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[5] = '{32'h8000_0020, 8'd5, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[6] = '{32'hC000_0000, 8'd5, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
      tv[7] = '{32'h1000_0000, 8'd5, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         c0_entryhi = {24'h004020, tv[i].asid};
         data_req = 1; data_vaddr = tv[i].va; data_wr = tv[i].wr; kseg0_uncache = tv[i].k0u;
         tick();
         chk("tv_valid", 32'(data_rsp_valid), 32'd1);
         chk("tv_paddr", data_paddr, tv[i].pa);
         chk("tv_unc", 32'(data_uncache), 32'(tv[i].unc));
         chk("tv_refill", 32'(data_refill), 32'(tv[i].rf));
         chk("tv_invalid", 32'(data_invalid), 32'(tv[i].inv));
         chk("tv_modified", 32'(data_modified), 32'(tv[i].md));
      end
      idle(); kseg0_uncache = 0;

      // Clean page: store faults as modified, load still hits
      c0_entryhi = 32'h0040_2005; c0_entrylo0 = 32'h0048_D15A; tlbwi = 1;
      tick();
      tlbwi = 0; data_req = 1; data_vaddr = 32'h0040_2ABC; data_wr = 1;
      tick();
      chk("mod_flag", 32'(data_modified), 32'd1);
      chk("mod_paddr", data_paddr, 32'h0);
      data_wr = 0;
      tick();
      chk("clean_load", data_paddr, 32'h1234_5ABC);

      // Global entry: any ASID hits
      data_req = 0; c0_entrylo0 = 32'h0048_D15B; c0_entrylo1 = 32'h1; tlbwi = 1;
      tick();
      tlbwi = 0; c0_entryhi = 32'h0040_2006; data_req = 1; data_vaddr = 32'h0040_2ABC;
      tick();
      chk("global_hit", data_paddr, 32'h1234_5ABC);
      chk("global_refill", 32'(data_refill), 32'd0);
      data_req = 0;

      // TLBP / TLBR
      c0_entryhi = 32'h0040_2005; tlbp = 1;
      tick();
      chk("tlbp_hit", tlbp_index, 32'd3);
      chk("tlbp_done", 32'(tlb_op_done), 32'd1);
      c0_entryhi = 32'h7000_0000;
      tick();
      chk("tlbp_miss", tlbp_index, 32'h8000_0000);
      tlbp = 0; tlbr = 1; c0_index = 32'd3;
      tick();
      chk("tlbr_hi", r_entryhi, 32'h0040_2005);
      chk("tlbr_lo0", r_entrylo0, 32'h0048_D15B);
      chk("tlbr_lo1", r_entrylo1, 32'h0000_0001);
      tlbr = 0;
      tick();
      chk("tlbr_hold", r_entryhi, 32'h0040_2005);
      // tlbr outranks tlbp: tlbp_index keeps its miss value
      c0_entryhi = 32'h0040_2005; tlbr = 1; tlbp = 1;
      tick();
      chk("prio_tlbp_drop", tlbp_index, 32'h8000_0000);
      idle();

      // TLBWR when Random reads 9
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         if (m_rand == 9) found = 1;
         else tick();
      end
      if (found == 0) chk("wait_rand9", 32'(m_rand), 32'd9);
      chk("rand_is9", 32'(random), 32'd9);
      c0_entryhi = 32'h0060_0007; c0_entrylo0 = 32'h0001_DDDF; c0_entrylo1 = 32'h1; tlbwr = 1;
      c0_index = 32'd3;
      tick();
      tlbwr = 0; tlbr = 1; c0_index = 32'd9;
      tick();
      chk("wr_e9_hi", r_entryhi, 32'h0060_0007);
      chk("wr_e9_lo0", r_entrylo0, 32'h0001_DDDF);
      c0_index = 32'd8;
      tick();
      chk("wr_e8_clear", r_entryhi, 32'h0);
      c0_index = 32'd3;
      tick();
      chk("wr_e3_kept", r_entryhi, 32'h0040_2005);
      tlbr = 0;

      // Wired at the top pins Random
      c0_wired = 4'd15;
      tick(); tick();
      chk("wired_top", 32'(random), 32'd15);
      c0_wired = 4'd4;

      // Write and lookup of the same page in one cycle
      c0_entryhi = 32'h0080_0005; c0_entrylo0 = {6'b0, 20'h00ABC, 3'd3, 1'b1, 1'b1, 1'b0};
      c0_entrylo1 = 32'h0; c0_index = 32'd5; tlbwi = 1;
      data_req = 1; data_vaddr = 32'h0080_0123;
      tick();
      chk("same_cyc_old", 32'(data_refill), 32'd1);
      tlbwi = 0;
      tick();
      chk("next_cyc_new", data_paddr, 32'h00AB_C123);
      chk("next_cyc_unc", 32'(data_uncache), 32'd0);
      idle();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         inst_req = 1'($urandom); inst_vaddr = pick_va();
         data_req = 1'($urandom); data_vaddr = pick_va(); data_wr = 1'($urandom);
         kseg0_uncache = ($urandom_range(0, 7) == 0);
         c0_entryhi = {pick_va() & 32'hFFFF_E000} | 32'($urandom_range(4, 6));
         c0_entrylo0 = $urandom; c0_entrylo1 = $urandom; c0_index = $urandom;
         tlbwi = ($urandom_range(0, 15) == 0); tlbwr = ($urandom_range(0, 15) == 0);
         tlbr  = ($urandom_range(0, 7) == 0);  tlbp  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 63) == 0) c0_wired = 4'($urandom_range(0, 15));
         tick();
      end
      c0_wired = 4'd4;

      // Asynchronous reset mid-stream, then the TLB must be empty
      c0_entryhi = 32'h0040_2005; c0_entrylo0 = 32'h0048_D15E; c0_index = 32'd3; tlbwi = 1;
      tick();
      tlbwi = 0; inst_req = 1; inst_vaddr = 32'h0040_2ABC; data_req = 1; data_vaddr = 32'h0040_2ABC;
      tlbp = 1;
      tick();
      @(posedge clk); #3;
      rst_n = 0;
      #1;
      mreset();
      cmp_all();
      chk("rst_random", 32'(random), 32'd15);
      idle();
      #3;
      rst_n = 1;
      data_req = 1; data_vaddr = 32'h0040_2ABC; c0_entryhi = 32'h0040_2005;
      tick();
      chk("post_rst_refill", 32'(data_refill), 32'd1);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
